// File: rtl/alu_op_sequencer_if.sv
// Control-side interface of the ALU operation sequencer: the start/done
// handshake from decode plus the register/bus strobes toward the datapath.
interface alu_op_sequencer_if #(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = 4,
    parameter int OP_W     = 5
);
    // Request from decode
    logic                start;
    logic [OP_W-1:0]     op_in;
    logic [IDX_W-1:0]    rs_idx;
    logic [IDX_W-1:0]    rt_idx;
    logic [IDX_W-1:0]    rd_idx;

    // Datapath strobes
    logic [NUM_REGS-1:0] rout;
    logic [NUM_REGS-1:0] rin;
    logic                yin;
    logic                zlowin;
    logic                zhighin;
    logic                zlowout;
    logic                zhighout;
    logic                loin;
    logic                hiin;
    logic [OP_W-1:0]     alu_op;

    // Handshake status
    logic                busy;
    logic                done;
    logic                err;

    // Decode side: issues requests, observes strobes and status
    modport master (
        output start, op_in, rs_idx, rt_idx, rd_idx,
        input  rout, rin, yin, zlowin, zhighin, zlowout, zhighout,
               loin, hiin, alu_op, busy, done, err
    );

    // Sequencer side
    modport slave (
        input  start, op_in, rs_idx, rt_idx, rd_idx,
        output rout, rin, yin, zlowin, zhighin, zlowout, zhighout,
               loin, hiin, alu_op, busy, done, err
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequencer for one register-register ALU instruction on the shared-bus
// datapath: A -> Y, B through the ALU -> Z, then Z written back either to
// Rd (narrow) or to LO/HI (wide). All strobes are Moore outputs.
module alu_op_sequencer #(
    parameter int                   NUM_REGS  = 16,
    parameter int                   IDX_W     = 4,
    parameter int                   OP_W      = 5,
    parameter logic [(2**OP_W)-1:0] WIDE_MASK = 32'h0000_0300,
    parameter bit                   R0_ZERO   = 1'b0
) (
    input  logic              i_clock,
    input  logic              i_clear,
    alu_op_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_Y,
        S_EXEC,
        S_WB_LO,
        S_WB_HI,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [OP_W-1:0]     r_op;
    logic [IDX_W-1:0]    r_rs;
    logic [IDX_W-1:0]    r_rt;
    logic [IDX_W-1:0]    r_rd;
    logic                r_wide;
    logic                r_err;

    logic                w_accept;
    logic                w_wide_in;
    logic                w_bad_in;
    logic [NUM_REGS-1:0] w_sel_rs;
    logic [NUM_REGS-1:0] w_sel_rt;
    logic [NUM_REGS-1:0] w_sel_rd;
    logic                w_rd_suppressed;

    // An index is unusable when it names a register that does not exist.
    function automatic logic idx_bad(input logic [IDX_W-1:0] idx);
        return 32'(idx) >= 32'(NUM_REGS);
    endfunction

    assign w_accept  = (r_state == S_IDLE) && bus.start;
    assign w_wide_in = WIDE_MASK[bus.op_in];
    // rd only matters for narrow ops; wide ops write LO/HI instead.
    assign w_bad_in  = idx_bad(bus.rs_idx) || idx_bad(bus.rt_idx) ||
                       (!w_wide_in && idx_bad(bus.rd_idx));

    // Illegal indices never reach a strobing state, so the shifts stay in range.
    assign w_sel_rs        = NUM_REGS'(1) << r_rs;
    assign w_sel_rt        = NUM_REGS'(1) << r_rt;
    assign w_sel_rd        = NUM_REGS'(1) << r_rd;
    assign w_rd_suppressed = R0_ZERO && (r_rd == '0);

    // State register; clear aborts any operation in flight.
    always_ff @(posedge i_clock) begin
        // NOTE: non-blocking so every flop samples pre-edge values.
        if (i_clear) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Instruction fields captured on the accepting edge only.
    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_op   <= '0;
            r_rs   <= '0;
            r_rt   <= '0;
            r_rd   <= '0;
            r_wide <= 1'b0;
            r_err  <= 1'b0;
        end else if (w_accept) begin
            r_op   <= bus.op_in;
            r_rs   <= bus.rs_idx;
            r_rt   <= bus.rt_idx;
            r_rd   <= bus.rd_idx;
            r_wide <= w_wide_in;
            r_err  <= w_bad_in;
        end
    end

    // Next-state: linear walk, illegal requests jump straight to DONE.
    always_comb begin
        // NOTE: default first so no path leaves w_next unassigned (no latch).
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (bus.start) w_next = w_bad_in ? S_DONE : S_LOAD_Y;
            S_LOAD_Y: w_next = S_EXEC;
            S_EXEC:   w_next = S_WB_LO;
            S_WB_LO:  w_next = r_wide ? S_WB_HI : S_DONE;
            S_WB_HI:  w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Moore strobes from state and latched fields; one bus driver per cycle.
    always_comb begin
        bus.rout     = '0;
        bus.rin      = '0;
        bus.yin      = 1'b0;
        bus.zlowin   = 1'b0;
        bus.zhighin  = 1'b0;
        bus.zlowout  = 1'b0;
        bus.zhighout = 1'b0;
        bus.loin     = 1'b0;
        bus.hiin     = 1'b0;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.err      = 1'b0;
        bus.alu_op   = (r_state == S_IDLE) ? '0 : r_op;
        unique case (r_state)
            S_LOAD_Y: begin
                bus.busy = 1'b1;
                bus.rout = w_sel_rs;
                bus.yin  = 1'b1;
            end
            S_EXEC: begin
                bus.busy    = 1'b1;
                bus.rout    = w_sel_rt;
                bus.zlowin  = 1'b1;
                bus.zhighin = 1'b1;
            end
            S_WB_LO: begin
                bus.busy    = 1'b1;
                bus.zlowout = 1'b1;
                if (r_wide)                bus.loin = 1'b1;
                else if (!w_rd_suppressed) bus.rin  = w_sel_rd;
            end
            S_WB_HI: begin
                bus.busy     = 1'b1;
                bus.zhighout = 1'b1;
                bus.hiin     = 1'b1;
            end
            S_DONE: begin
                bus.done = 1'b1;
                bus.err  = r_err;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a default instance (16 regs) with a small
// shared-bus datapath model, and a 12-register instance with R0 writes
// suppressed. Expected strobe traces come from a spec-level model queue.
module tb_alu_op_sequencer;

    typedef struct packed {
        logic [15:0] rout;
        logic [15:0] rin;
        logic        yin;
        logic        zlowin;
        logic        zhighin;
        logic        zlowout;
        logic        zhighout;
        logic        loin;
        logic        hiin;
        logic [4:0]  alu_op;
        logic        busy;
        logic        done;
        logic        err;
    } out_t;

    typedef struct {
        int         inst;
        logic [4:0] op;
        logic [3:0] rs;
        logic [3:0] rt;
        logic [3:0] rd;
        bit         noisy;
        int         exp_lat;
        bit         exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic clear;
    always #5 clk = ~clk;

    alu_op_sequencer_if #(.NUM_REGS(16), .IDX_W(4), .OP_W(5)) b0 ();
    alu_op_sequencer_if #(.NUM_REGS(12), .IDX_W(4), .OP_W(5)) b1 ();

    alu_op_sequencer #(.NUM_REGS(16), .IDX_W(4), .OP_W(5),
                       .WIDE_MASK(32'h0000_0300), .R0_ZERO(1'b0))
        u_dut0 (.i_clock(clk), .i_clear(clear), .bus(b0.slave));

    alu_op_sequencer #(.NUM_REGS(12), .IDX_W(4), .OP_W(5),
                       .WIDE_MASK(32'h0000_0300), .R0_ZERO(1'b1))
        u_dut1 (.i_clock(clk), .i_clear(clear), .bus(b1.slave));

    out_t o0, o1;
    assign o0 = {b0.rout, b0.rin, b0.yin, b0.zlowin, b0.zhighin, b0.zlowout,
                 b0.zhighout, b0.loin, b0.hiin, b0.alu_op, b0.busy, b0.done, b0.err};
    assign o1 = {4'b0, b1.rout, 4'b0, b1.rin, b1.yin, b1.zlowin, b1.zhighin,
                 b1.zlowout, b1.zhighout, b1.loin, b1.hiin, b1.alu_op, b1.busy,
                 b1.done, b1.err};

    // Shared-bus datapath model driven by instance 0's strobes.
    logic [31:0] dp_reg [16];
    logic [31:0] dp_y, dp_zl, dp_zh, dp_lo, dp_hi;
    logic [31:0] dp_bus;

    function automatic logic [63:0] alu(input logic [4:0] op, input logic [31:0] a, b);
        case (op)
            5'd1:    return 64'(a & b);
            5'd8:    return 64'(a) * 64'(b);
            default: return 64'(a + b);
        endcase
    endfunction

    always_comb begin
        dp_bus = '0;
        for (int i = 0; i < 16; i++) if (b0.rout[i]) dp_bus = dp_reg[i];
        if (b0.zlowout)  dp_bus = dp_zl;
        if (b0.zhighout) dp_bus = dp_zh;
    end

    always @(posedge clk) begin
        if (clear) begin
            dp_reg[2] <= 32'd12;
            dp_reg[3] <= 32'd5;
            dp_reg[4] <= 32'h0001_2345;
            dp_reg[5] <= 32'h0001_0000;
        end else begin
            if (b0.yin)    dp_y <= dp_bus;
            if (b0.zlowin) {dp_zh, dp_zl} <= alu(b0.alu_op, dp_y, dp_bus);
            for (int i = 0; i < 16; i++) if (b0.rin[i]) dp_reg[i] <= dp_bus;
            if (b0.loin)   dp_lo <= dp_bus;
            if (b0.hiin)   dp_hi <= dp_bus;
        end
    end

    int   n_checks = 0;
    int   n_fail   = 0;
    out_t sb [$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input int inst, input logic st, input logic [4:0] op,
                         input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd);
        if (inst == 0) begin
            b0.start = st; b0.op_in = op; b0.rs_idx = rs; b0.rt_idx = rt; b0.rd_idx = rd;
        end else begin
            b1.start = st; b1.op_in = op; b1.rs_idx = rs; b1.rt_idx = rt; b1.rd_idx = rd;
        end
    endtask

    task automatic set_start(input int inst, input logic st);
        if (inst == 0) b0.start = st;
        else           b1.start = st;
    endtask

    // Expected per-cycle trace after an accepting edge, ending with one IDLE cycle.
    task automatic model_push(input int inst, input logic [4:0] op,
                              input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd);
        logic [31:0] wide_mask = 32'h0000_0300;
        int   nregs = (inst == 0) ? 16 : 12;
        bit   r0z   = (inst == 1);
        bit   wide  = wide_mask[op];
        bit   bad   = (int'(rs) >= nregs) || (int'(rt) >= nregs) ||
                      (!wide && int'(rd) >= nregs);
        out_t o;
        if (!bad) begin
            o = '0; o.busy = 1; o.alu_op = op; o.rout = 16'(1) << rs; o.yin = 1;
            sb.push_back(o);
            o = '0; o.busy = 1; o.alu_op = op; o.rout = 16'(1) << rt;
            o.zlowin = 1; o.zhighin = 1;
            sb.push_back(o);
            o = '0; o.busy = 1; o.alu_op = op; o.zlowout = 1;
            if (wide)                   o.loin = 1;
            else if (!(r0z && rd == 0)) o.rin  = 16'(1) << rd;
            sb.push_back(o);
            if (wide) begin
                o = '0; o.busy = 1; o.alu_op = op; o.zhighout = 1; o.hiin = 1;
                sb.push_back(o);
            end
        end
        o = '0; o.alu_op = op; o.done = 1; o.err = bad;
        sb.push_back(o);
        o = '0;
        sb.push_back(o);
    endtask

    // Pop and compare one expected record per cycle until the queue drains.
    task automatic run_sb(input bit hold, input bit noisy, input int inst,
                          output int lat, output logic err_at_done);
        int   cyc = 0;
        out_t exp_o, got_o;
        lat = -1;
        err_at_done = 1'b0;
        @(negedge clk);
        while (sb.size() > 0) begin
            cyc++;
            exp_o = sb.pop_front();
            got_o = (inst == 0) ? o0 : o1;
            check($sformatf("inst%0d cycle%0d", inst, cyc), 64'(got_o), 64'(exp_o));
            if (got_o.done && lat < 0) begin
                lat = cyc;
                err_at_done = got_o.err;
            end
            if (hold) set_start(inst, sb.size() > 0);
            else drive(inst, noisy && sb.size() > 0, 5'($urandom), 4'($urandom),
                       4'($urandom), 4'($urandom));
            @(negedge clk);
        end
    endtask

    function automatic vec_t mk(input int inst, input logic [4:0] op, input logic [3:0] rs,
                                input logic [3:0] rt, input logic [3:0] rd, input bit noisy,
                                input int lat, input bit err);
        vec_t v;
        v.inst = inst; v.op = op; v.rs = rs; v.rt = rt; v.rd = rd;
        v.noisy = noisy; v.exp_lat = lat; v.exp_err = err;
        return v;
    endfunction

    initial begin
        vec_t vecs [$];
        int   lat;
        logic e;

        vecs.push_back(mk(0,  1,  2,  3,  1, 0, 4, 0)); // narrow AND
        vecs.push_back(mk(0,  8,  4,  5,  7, 0, 5, 0)); // wide multiply
        vecs.push_back(mk(0,  9, 15, 15, 15, 1, 5, 0)); // wide, starts while busy
        vecs.push_back(mk(0,  3,  6,  6,  6, 1, 4, 0)); // rs=rt=rd aliasing
        vecs.push_back(mk(0,  2,  0,  1,  0, 0, 4, 0)); // rd=0 written when allowed
        vecs.push_back(mk(1,  4,  1,  2,  0, 0, 4, 0)); // rd=0 suppressed
        vecs.push_back(mk(1,  4, 13,  2,  3, 0, 1, 1)); // illegal rs
        vecs.push_back(mk(1,  5,  3,  4,  5, 0, 4, 0)); // legal clears err
        vecs.push_back(mk(1,  8,  2,  3, 14, 0, 5, 0)); // wide ignores bad rd
        vecs.push_back(mk(1,  1,  1, 12,  2, 0, 1, 1)); // rt at NUM_REGS
        vecs.push_back(mk(1,  1,  1,  2, 12, 0, 1, 1)); // narrow rd at NUM_REGS
        vecs.push_back(mk(1, 31, 11, 11, 11, 0, 4, 0)); // top legal index

        clear = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("reset inst0", 64'(o0), 64'(0));
        check("reset inst1", 64'(o1), 64'(0));
        clear = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            drive(vecs[i].inst, 1, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd);
            model_push(vecs[i].inst, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd);
            run_sb(0, vecs[i].noisy, vecs[i].inst, lat, e);
            check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            check($sformatf("vec%0d err", i), 64'(e), 64'(vecs[i].exp_err));
            if (i == 0) check("R1 after AND", 64'(dp_reg[1]), 64'd4);
            if (i == 1) begin
                check("LO after multiply", 64'(dp_lo), 64'h2345_0000);
                check("HI after multiply", 64'(dp_hi), 64'h0000_0001);
            end
        end

        // start held high: second LOAD_Y two cycles after the first done
        drive(0, 1, 1, 2, 3, 1);
        model_push(0, 1, 2, 3, 1);
        model_push(0, 1, 2, 3, 1);
        run_sb(1, 0, 0, lat, e);
        check("back-to-back first latency", 64'(lat), 64'd4);

        // clear during EXEC of a wide op: no writeback, no done afterwards
        drive(0, 1, 8, 4, 5, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        check("abort LOAD_Y yin", 64'(o0.yin), 64'd1);
        @(negedge clk);
        check("abort EXEC zlowin", 64'(o0.zlowin), 64'd1);
        clear = 1'b1;
        @(negedge clk);
        check("abort outputs cleared", 64'(o0), 64'(0));
        clear = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("abort quiet cycle%0d", c), 64'(o0), 64'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Parametrised control sequencer that issues the bus/register strobe sequence for one register-register ALU instruction (Rd <- Rs op Rt) on the shared-bus datapath: operand A to Y, operand B through the ALU into Z, then Z written back.
Replaces hand-sequenced strobes with a start/done handshake and supports a wide mode that writes the 64-bit Z result to LO/HI for multiply/divide-class ops.
Sits between the instruction decode logic and the data_path control inputs.

Parameters:
NUM_REGS, 16, number of general registers; width of the one-hot Rout/Rin vectors.
IDX_W, 4, register index width; must satisfy 2^IDX_W >= NUM_REGS.
OP_W, 5, ALU opcode width.
WIDE_MASK, 32'h0000_0300, bit n set means opcode n is wide (Zlow->LO, Zhigh->HI); width 2^OP_W.
R0_ZERO, 0, 1 = writes to register 0 suppressed (Rin[0] never asserted).

Ports:
Clock  in  1  system clock; all state changes on the rising edge.
clear  in  1  synchronous active-high reset.
start  in  1  request; sampled only in IDLE.
op_in  in  OP_W  ALU opcode.
rs_idx  in  IDX_W  source A index.
rt_idx  in  IDX_W  source B index.
rd_idx  in  IDX_W  destination index (ignored for wide ops).
Rout  out  NUM_REGS  one-hot register-to-bus enables.
Rin  out  NUM_REGS  one-hot bus-to-register enables.
Yin  out  1  Y register load.
Zlowin  out  1  Z low load.
Zhighin  out  1  Z high load.
Zlowout  out  1  Z low to bus.
Zhighout  out  1  Z high to bus.
LOin  out  1  LO load.
HIin  out  1  HI load.
alu_op  out  OP_W  opcode to ALU.
busy  out  1  high from LOAD_Y through WB_HI.
done  out  1  one-cycle completion pulse.
err  out  1  valid with done; illegal index.

Behaviour:
- Reset: clear=1 at a rising edge -> state IDLE, latches zeroed; all outputs 0 in the following cycle. Overrides everything, including mid-operation (no partial writeback after abort).
- Moore outputs decoded from the registered state and latched fields only; no input-to-output combinational path.
- States: IDLE, LOAD_Y, EXEC, WB_LO, WB_HI, DONE.
- IDLE: start=1 at an edge latches op_in, rs_idx, rt_idx, rd_idx and computes wide = WIDE_MASK[op_in].
  - Any used index >= NUM_REGS (rs, rt; rd only if not wide) -> DONE with err latched 1.
  - Otherwise -> LOAD_Y.
- LOAD_Y: Rout[rs]=1, Yin=1 -> EXEC.
- EXEC: Rout[rt]=1, Zlowin=1, Zhighin=1 -> WB_LO.
- WB_LO: Zlowout=1.
  - Wide: LOin=1 -> WB_HI.
  - Narrow: Rin[rd]=1 (suppressed if R0_ZERO and rd=0) -> DONE.
- WB_HI: Zhighout=1, HIin=1 -> DONE.
- DONE: done=1, err=latched value -> IDLE unconditionally. start is ignored in DONE; earliest next acceptance is the IDLE cycle after.
- alu_op = latched op while busy or in DONE; 0 in IDLE.
- Latency from the accepting edge to the done cycle: narrow 4 cycles, wide 5 cycles, illegal 1 cycle.
- Exactly one bus driver (at most one Rout bit, or one Z*out) is active in any cycle.
- rs=rt, rd=rs, and rd=rt are legal: reads precede the write.
- Inputs other than start/clear are don't-care outside the accepting edge; changes while busy have no effect.
- err is cleared on the next accepted start.

Test Plan:
1. Reset mid-op: assert clear during EXEC -> next cycle all outputs 0, state IDLE, no Rin/LOin pulse afterwards, no done.
2. Narrow AND: op=1, rs=2, rt=3, rd=1, start 1 cycle -> Rout=16'h0004+Yin; then Rout=16'h0008+Zlowin+Zhighin with alu_op=1; then Zlowout+Rin=16'h0002; then done=1, err=0; 4 cycles total. With datapath R2=12, R3=5, R1 reads 4.
3. Wide op: op=8, rs=4, rt=5 -> after EXEC, Zlowout+LOin, then Zhighout+HIin, no Rin bits; done 5 cycles after start.
4. R0_ZERO=1, rd=0 narrow op -> Rin stays 0 all cycles; done still at cycle 4.
5. Illegal index with NUM_REGS=12: rs=13 -> done+err=1 next cycle, no strobes. A following legal start clears err.
6. Back-to-back and ignored starts: start held high continuously -> second op's LOAD_Y begins two cycles after the first done (DONE->IDLE->LOAD_Y); start pulses while busy are not accepted.
